uart_rx: RTL
============

# uart_rx

Serial receiver that pairs with the team's UART transmitter on the far end of the same link. It uses the same frame format: 1 start bit, 8 data bits LSB first, 1 parity bit (even or odd), and 1 or 2 stop bits. Line timing comes from a system-clock baud divisor rather than an oversampling clock. Recovered bytes go to the core as a one-cycle valid pulse, with parity and framing status attached.

## Interface
- BAUD_DIVISOR, 868, system clocks per bit (100 MHz / 115200); must be even and at least 8
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- Rx_en  in  1  receiver enable; sampled only in IDLE
- Two_stop  in  1  1 = expect two stop bits; latched at start detect
- Odd_parity  in  1  1 = odd parity, 0 = even; latched at start detect
- Rx_in  in  1  asynchronous serial line; idle high
- rx_data  out  8  last received byte; held until the next frame completes
- rx_valid  out  1  one-cycle pulse when rx_data, parity_err and frame_err update
- parity_err  out  1  parity mismatch on the last frame
- frame_err  out  1  a stop bit of the last frame sampled low

## Operation
- Rx_in passes through a 2-flop synchronizer. All logic below uses the synchronized value rx_s.
- Shared baud counter is 14 bits wide. It clears on every state entry and on every sample. HALF = BAUD_DIVISOR/2.
- IDLE:
  - If Rx_en=1 and rx_s=0, latch Two_stop and Odd_parity, then go to START.
- START:
  - Sample when count == HALF-1.
  - rx_s=1 means a glitch: go to IDLE with no output.
  - rx_s=0: go to DATA with bit counter = 0.
- DATA:
  - Sample when count == BAUD_DIVISOR-1.
  - Shift rx_s into the MSB of the shift register (right shift), so the LSB arrives first.
  - After the 8th sample, go to PARITY.
- PARITY:
  - Sample once. Error term = (^shift ^ sample) != Odd_parity_r.
- STOP:
  - Sample stop 1. If Two_stop_r=1, sample stop 2 one BAUD_DIVISOR later.
  - frame_err term = OR of (sample == 0) over all stop samples.
- DONE (one cycle):
  - Register rx_data, parity_err and frame_err together. Assert rx_valid.
  - Go to IDLE if no frame error; otherwise go to WAIT_HIGH.
- WAIT_HIGH:
  - Stay until rx_s=1, then go to IDLE. This prevents a break or a stuck-low line from retriggering reception.
- Rx_en deasserted mid-frame has no effect; the frame completes.
- Two_stop and Odd_parity changing mid-frame have no effect.
- The error flags are per-frame, not sticky. A later good frame clears them at its DONE cycle.

## Timing
- Reset values:
  - rx_data = 8'h00
  - rx_valid = 0
  - parity_err = 0
  - frame_err = 0
  - state = IDLE; counters = 0
  - synchronizer flops = 1
- Reset is effective the cycle it is asserted, including mid-frame. The partial frame is discarded with no rx_valid.
- Rx_in falling edge reaches rx_s after 2 clk edges. The IDLE→START transition happens on the next edge.
- Cycle counts, measured from the first cycle in START:
  - Start-bit check at cycle HALF.
  - Data bit i (i = 0..7) sampled at HALF + (i+1)·BAUD_DIVISOR.
  - Parity sampled at HALF + 9·BAUD_DIVISOR.
  - Stop 1 sampled at HALF + 10·BAUD_DIVISOR.
  - Stop 2 (if enabled) sampled at HALF + 11·BAUD_DIVISOR.
- rx_valid is high in the cycle after the last stop sample.
- IDLE is re-entered mid-stop-bit. Back-to-back frames are therefore accepted with no idle gap.
- rx_valid is never high two consecutive cycles. It carries no backpressure; the consumer must capture it in the same cycle.

## Configuration
- UART_RX_MAJORITY_EN is the only macro.
- Defined:
  - Each sample point (start check, data, parity, stop) takes a 2-of-3 majority of rx_s.
  - The three values are taken at the sample count and at the two cycles before it.
  - The decision cycle is unchanged.
- Undefined:
  - A single sample of rx_s is taken at the sample count.
- All latencies are identical in both builds.

## Structure
- Package uart_pkg holds:
  - the state enum: IDLE, START, DATA, PARITY, STOP, DONE, WAIT_HIGH
  - the BAUD_DIVISOR default
  - the baud-counter width constant
- The Tx block will share this package.
- One sub-module, uart_sync2: a 2-flop synchronizer with parameterized reset value (1 here). It is reusable on other asynchronous inputs.
- Everything else stays flat in uart_rx: FSM, baud counter, bit counter, shift register, output registers.

## Test plan
All scenarios use BAUD_DIVISOR=16.
- Even parity, one stop, byte 8'hA5 (parity bit 0) → one rx_valid pulse; rx_data=8'hA5, parity_err=0, frame_err=0. Pulse lands at start + 8 + 10·16 + 1 cycles after rx_s falls.
- Odd parity, two stops, 8'h3C, wrong parity bit driven → rx_data=8'h3C, parity_err=1. A following correct frame 8'h01 → parity_err=0.
- Low glitch of 4 clk on the idle line → no rx_valid; FSM back in IDLE. A subsequent 8'h55 frame is received correctly.
- Stop bit driven low, line held low for 100 bits, then released, then frame 8'hFF → first frame frame_err=1; exactly two rx_valid pulses in total; the second carries 8'hFF with frame_err=0.
- rst asserted for 1 cycle mid-data of frame 8'h12, then frame 8'h34 → only 8'h34 is reported; all outputs read 0 the cycle after rst.
- Back-to-back frames 8'h00, 8'hFF with no idle gap, Rx_en dropped during the second → both received; Rx_en=0 afterwards blocks a third frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, default baud divisor, baud-counter width.
// Used by both the receiver and transmitter sides of the link.
package uart_pkg;

    localparam int BAUD_DIVISOR_DEF = 868;
    localparam int CNT_W            = 14;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE,
        WAIT_HIGH
    } state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; reset value is a parameter.
// Latency: 2 clk edges; no backpressure.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, 1/2 stop; divisor-timed sampling.
// Latency: rx_valid one cycle after the last stop sample. No backpressure: rx_valid is a 1-cycle pulse.
// UART_RX_MAJORITY_EN: 2-of-3 majority vote over the sample cycle and the two before it.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIVISOR = BAUD_DIVISOR_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rx_en,
    input  logic       Two_stop,
    input  logic       Odd_parity,
    input  logic       Rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BAUD_DIVISOR / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BAUD_DIVISOR - 1);

    logic rx_s;
    logic samp;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             two_stop_q, two_stop_d;
    logic             odd_q, odd_d;
    logic             stop2_q, stop2_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             ferr_new;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Rx_in),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rx_s one cycle back, hist_q[1] two cycles back
    logic [1:0] hist_q, hist_d;
    always_comb begin
        hist_d = {hist_q[0], rx_s};
        samp   = maj3(rx_s, hist_q[0], hist_q[1]);
    end
`else
    always_comb samp = rx_s;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        two_stop_d   = two_stop_q;
        odd_d        = odd_q;
        stop2_d      = stop2_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        ferr_new     = ferr_q | ~samp;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                if (Rx_en && !rx_s) begin
                    two_stop_d = Two_stop;
                    odd_d      = Odd_parity;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    shift_d   = {samp, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    perr_d  = ((^shift_q) ^ samp) != odd_q;
                    ferr_d  = 1'b0;
                    stop2_d = 1'b0;
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FULL_M1) begin
                    cnt_d  = '0;
                    ferr_d = ferr_new;
                    if (two_stop_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        // Outputs update together so rx_valid is high during the DONE cycle
                        rx_data_d    = shift_q;
                        parity_err_d = perr_q;
                        frame_err_d  = ferr_new;
                        rx_valid_d   = 1'b1;
                        state_d      = DONE;
                    end
                end
            end
            DONE: begin
                state_d = frame_err_q ? WAIT_HIGH : IDLE;
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            two_stop_q   <= 1'b0;
            odd_q        <= 1'b0;
            stop2_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q       <= 2'b11;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            two_stop_q   <= two_stop_d;
            odd_q        <= odd_d;
            stop2_q      <= stop2_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q       <= hist_d;
`endif
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule
